// File: rtl/systolic_seq_ctrl.sv
// Operand banks and skewed wavefront sequencer for a 4x4 output-stationary systolic array.
// Latency start->done_o = 9+DRAIN_CYCLES edges; no backpressure, and loads during CLEAR/FEED/DRAIN are dropped with ld_err_o.
module systolic_seq_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ld_a_we_i,
    input  logic                  ld_b_we_i,
    input  logic [3:0]            ld_addr_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    output logic                  ld_err_o,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  arr_rst_no,
    output logic [DATA_WIDTH-1:0] left_o_0,
    output logic [DATA_WIDTH-1:0] left_o_1,
    output logic [DATA_WIDTH-1:0] left_o_2,
    output logic [DATA_WIDTH-1:0] left_o_3,
    output logic [DATA_WIDTH-1:0] up_o_0,
    output logic [DATA_WIDTH-1:0] up_o_1,
    output logic [DATA_WIDTH-1:0] up_o_2,
    output logic [DATA_WIDTH-1:0] up_o_3
);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic [3:0]            drain_q, drain_d;
    logic [DATA_WIDTH-1:0] a_q [16];
    logic [DATA_WIDTH-1:0] b_q [16];
    logic [DATA_WIDTH-1:0] left_q [4];
    logic [DATA_WIDTH-1:0] left_d [4];
    logic [DATA_WIDTH-1:0] up_q [4];
    logic [DATA_WIDTH-1:0] up_d [4];
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  arr_rst_q, arr_rst_d;
    logic                  ld_err_q, ld_err_d;
    logic                  ld_req, ld_ok;
    logic [3:0]            off;

    assign ld_req = ld_a_we_i | ld_b_we_i;
    assign ld_ok  = (state_q == S_IDLE) || (state_q == S_DONE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                step_d  = '0;
            end
            S_FEED: begin
                if (step_q == 3'd6) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 4'(DRAIN_CYCLES - 1)) state_d = S_DONE;
                else                                 drain_d = drain_q + 4'd1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that every port is a flop.
    always_comb begin
        busy_d    = (state_d == S_CLEAR) || (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d    = (state_d == S_DONE);
        arr_rst_d = (state_d != S_CLEAR);
        ld_err_d  = ld_req & ~ld_ok;
        off       = '0;
        for (int i = 0; i < 4; i++) begin
            left_d[i] = '0;
            up_d[i]   = '0;
            off       = {1'b0, step_d} - 4'(i);
            if (state_d == S_FEED && {1'b0, step_d} >= 4'(i) && off <= 4'd3) begin
                left_d[i] = a_q[{2'(i), off[1:0]}];
                up_d[i]   = b_q[{off[1:0], 2'(i)}];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arr_rst_q <= 1'b0;
            ld_err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                left_q[i] <= '0;
                up_q[i]   <= '0;
            end
            for (int k = 0; k < 16; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            done_q    <= done_d;
            arr_rst_q <= arr_rst_d;
            ld_err_q  <= ld_err_d;
            for (int i = 0; i < 4; i++) begin
                left_q[i] <= left_d[i];
                up_q[i]   <= up_d[i];
            end
            if (ld_ok && ld_a_we_i) a_q[ld_addr_i] <= ld_data_i;
            if (ld_ok && ld_b_we_i) b_q[ld_addr_i] <= ld_data_i;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign arr_rst_no = arr_rst_q;
    assign ld_err_o   = ld_err_q;
    assign left_o_0   = left_q[0];
    assign left_o_1   = left_q[1];
    assign left_o_2   = left_q[2];
    assign left_o_3   = left_q[3];
    assign up_o_0     = up_q[0];
    assign up_o_1     = up_q[1];
    assign up_o_2     = up_q[2];
    assign up_o_3     = up_q[3];

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl: reset, skew, latency, load rejection and start handling.
module tb_systolic_seq_ctrl;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          ld_a_we_i, ld_b_we_i;
    logic [3:0]    ld_addr_i;
    logic [DW-1:0] ld_data_i;
    logic          ld_err_o, start_i, busy_o, done_o, arr_rst_no;
    logic [DW-1:0] left_o_0, left_o_1, left_o_2, left_o_3;
    logic [DW-1:0] up_o_0, up_o_1, up_o_2, up_o_3;

    int total = 0;
    int bad   = 0;

    wire [DW-1:0] feed_or = left_o_0 | left_o_1 | left_o_2 | left_o_3 |
                            up_o_0 | up_o_1 | up_o_2 | up_o_3;

    always #5 clk = ~clk;

    systolic_seq_ctrl #(.DATA_WIDTH(DW), .DRAIN_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .ld_a_we_i(ld_a_we_i), .ld_b_we_i(ld_b_we_i),
        .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i), .ld_err_o(ld_err_o),
        .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .arr_rst_no(arr_rst_no),
        .left_o_0(left_o_0), .left_o_1(left_o_1), .left_o_2(left_o_2), .left_o_3(left_o_3),
        .up_o_0(up_o_0), .up_o_1(up_o_1), .up_o_2(up_o_2), .up_o_3(up_o_3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic wa, input logic wb, input logic [3:0] addr, input logic [DW-1:0] data);
        ld_a_we_i = wa;
        ld_b_we_i = wb;
        ld_addr_i = addr;
        ld_data_i = data;
        step();
        ld_a_we_i = 1'b0;
        ld_b_we_i = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step();
            if (done_o) seen = 1'b1;
        end
        chk("wait_done", {63'd0, seen}, 64'd1);
        step();
    endtask

    initial begin
        int busy_cnt, done_cnt, first_done, clear2;
        logic [DW-1:0] acc;

        rst_i = 1'b1; start_i = 1'b0;
        ld_a_we_i = 1'b0; ld_b_we_i = 1'b0; ld_addr_i = '0; ld_data_i = '0;
        step(); step();
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_done", {63'd0, done_o}, 64'd0);
        chk("rst_arr", {63'd0, arr_rst_no}, 64'd0);
        chk("rst_feeds", {32'd0, feed_or}, 64'd0);
        rst_i = 1'b0;
        step();
        chk("post_rst_arr", {63'd0, arr_rst_no}, 64'd1);

        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                load(1'b1, 1'b0, 4'(r*4+c), DW'(1 + 4*r + c));
                load(1'b0, 1'b1, 4'(r*4+c), DW'(17 + 4*r + c));
            end
        chk("idle_ld_err", {63'd0, ld_err_o}, 64'd0);

        // Main run: skew, latency, dropped load in FEED, start ignored in DRAIN/DONE.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("clear_arr", {63'd0, arr_rst_no}, 64'd0);
        busy_cnt = busy_o ? 1 : 0;
        done_cnt = 0;
        for (int n = 2; n <= 22; n++) begin
            if (n == 6) begin
                ld_a_we_i = 1'b1; ld_addr_i = 4'd5; ld_data_i = 99;
            end else begin
                ld_a_we_i = 1'b0;
            end
            start_i = (n >= 11 && n <= 14);
            step();
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (n == 2) chk("feed_arr", {63'd0, arr_rst_no}, 64'd1);
            if (n == 4) begin
                chk("t2_left0", {32'd0, left_o_0}, 64'd3);
                chk("t2_left1", {32'd0, left_o_1}, 64'd6);
                chk("t2_left2", {32'd0, left_o_2}, 64'd9);
                chk("t2_left3", {32'd0, left_o_3}, 64'd0);
                chk("t2_up0", {32'd0, up_o_0}, 64'd25);
                chk("t2_up1", {32'd0, up_o_1}, 64'd22);
                chk("t2_up2", {32'd0, up_o_2}, 64'd19);
                chk("t2_up3", {32'd0, up_o_3}, 64'd0);
            end
            if (n == 6) chk("ld_err_pulse", {63'd0, ld_err_o}, 64'd1);
            if (n == 7) chk("ld_err_clear", {63'd0, ld_err_o}, 64'd0);
            if (n == 8) begin
                chk("t6_left3", {32'd0, left_o_3}, 64'd16);
                chk("t6_up3", {32'd0, up_o_3}, 64'd32);
                chk("t6_others", {32'd0, left_o_0 | left_o_1 | left_o_2 | up_o_0 | up_o_1 | up_o_2}, 64'd0);
            end
            if (n == 9)  chk("drain_feeds", {32'd0, feed_or}, 64'd0);
            if (n == 12) chk("done_not_early", {63'd0, done_o}, 64'd0);
            if (n == 13) begin
                chk("done_at_13", {63'd0, done_o}, 64'd1);
                chk("done_busy", {63'd0, busy_o}, 64'd0);
            end
        end
        start_i = 1'b0;
        chk("busy_cycles", 64'(busy_cnt), 64'd12);
        chk("done_count", 64'(done_cnt), 64'd1);

        // Rejected load left A[1][1] intact; then reset mid-FEED.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int n = 2; n <= 5; n++) begin
            step();
            if (n == 4) chk("keep_a11", {32'd0, left_o_1}, 64'd6);
        end
        rst_i = 1'b1;
        step();
        chk("midrst_busy", {63'd0, busy_o}, 64'd0);
        chk("midrst_arr", {63'd0, arr_rst_no}, 64'd0);
        chk("midrst_feeds", {32'd0, feed_or}, 64'd0);
        step();
        rst_i = 1'b0;
        step();
        chk("midrst_rel_arr", {63'd0, arr_rst_no}, 64'd1);
        chk("midrst_rel_busy", {63'd0, busy_o}, 64'd0);
        done_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            step();
            if (done_o) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        start_i = 1'b1;
        step();
        start_i = 1'b0;
        acc = '0;
        for (int n = 2; n <= 13; n++) begin
            step();
            acc = acc | feed_or;
            if (n == 13) chk("zero_run_done", {63'd0, done_o}, 64'd1);
        end
        chk("zero_banks_feed", {32'd0, acc}, 64'd0);
        step();

        // start held high: second CLEAR two cycles after the first done.
        start_i = 1'b1;
        step();
        first_done = 0;
        clear2 = 0;
        for (int n = 2; n <= 17; n++) begin
            step();
            if (done_o && first_done == 0) first_done = n;
            if (!arr_rst_no && clear2 == 0) clear2 = n;
        end
        start_i = 1'b0;
        chk("held_first_done", 64'(first_done), 64'd13);
        chk("held_second_clear", 64'(clear2), 64'd15);
        wait_done();

        // Load both banks and start on the same edge.
        ld_a_we_i = 1'b1; ld_b_we_i = 1'b1; ld_addr_i = 4'd0; ld_data_i = 7; start_i = 1'b1;
        step();
        ld_a_we_i = 1'b0; ld_b_we_i = 1'b0; start_i = 1'b0;
        step();
        chk("sim_left0", {32'd0, left_o_0}, 64'd7);
        chk("sim_up0", {32'd0, up_o_0}, 64'd7);
        chk("sim_ld_err", {63'd0, ld_err_o}, 64'd0);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
- Sequencer for the 4x4 output-stationary systolic multiplier (16 PEs, DATA_WIDTH operands).
- Holds operand matrices A and B in internal register banks.
- On start, clears the array accumulators, then drives the skewed left/up operand wavefronts.
- Waits for the array to drain, then pulses done. It sits between the operand-load path and the array's left_i_*/up_i_*/rst_ni inputs.

Parameters:
- DATA_WIDTH, 32, operand width of every bank entry and every feed output.
- DRAIN_CYCLES, 4, cycles of zero feed after the last wavefront before done. Legal range is 1..15.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- ld_a_we_i  input  1  write ld_data_i into A[ld_addr_i].
- ld_b_we_i  input  1  write ld_data_i into B[ld_addr_i].
- ld_addr_i  input  4  element index, row*4+col.
- ld_data_i  input  DATA_WIDTH  write data.
- ld_err_o  output  1  one-cycle pulse when a load is rejected.
- start_i  input  1  request a multiply.
- busy_o  output  1  high in CLEAR, FEED and DRAIN.
- done_o  output  1  one-cycle completion pulse.
- arr_rst_no  output  1  active-low reset to the systolic array.
- left_o_0, left_o_1, left_o_2, left_o_3  output  DATA_WIDTH each  row feeds. These connect to array inputs left_i_0, left_i_4, left_i_8, left_i_12.
- up_o_0, up_o_1, up_o_2, up_o_3  output  DATA_WIDTH each  column feeds. These connect to array inputs up_i_0..up_i_3.

Behaviour:
- Reset (rst_i high at an edge):
  - State goes to IDLE; the step and drain counters go to 0.
  - Both banks (32 entries) are cleared to 0.
  - All feed outputs are 0; busy_o, done_o and ld_err_o are 0.
  - arr_rst_no is 0 while rst_i is high, and 1 from the first non-reset cycle in IDLE.
  - Reset mid-operation aborts immediately. No done_o is produced.
- All outputs are registered.
- States: IDLE, CLEAR, FEED, DONE, plus DRAIN.
- IDLE:
  - busy_o=0, outputs=0.
  - start_i=1 at an edge moves to CLEAR.
- CLEAR:
  - One cycle. arr_rst_no=0, busy_o=1, feeds=0.
  - Next state is FEED with step t=0.
- FEED:
  - Seven cycles, t=0..6. busy_o=1, arr_rst_no=1.
  - left_o_i = A[i][t-i] when 0<=t-i<=3, else 0.
  - up_o_j = B[t-j][j] when 0<=t-j<=3, else 0.
  - After t=6 the next state is DRAIN.
- DRAIN:
  - DRAIN_CYCLES cycles with feeds=0 and busy_o=1.
  - Then the next state is DONE.
- DONE:
  - One cycle. done_o=1, busy_o=0, feeds=0.
  - Next state is IDLE unconditionally.
  - Array results remain valid until the next CLEAR.
- Latency:
  - Counted from the edge that samples start_i in IDLE.
  - CLEAR is visible after edge 1.
  - FEED t=0 is visible after edge 2.
  - done_o is visible after edge 9+DRAIN_CYCLES, which is 13 by default.
- start_i rules:
  - Ignored outside IDLE, including during the DONE cycle. It is not queued.
  - Held high continuously, it gives back-to-back operations separated by exactly one IDLE cycle.
- Loads:
  - Accepted in IDLE and DONE; the write takes effect at the edge.
  - A load in CLEAR, FEED or DRAIN is dropped, and the banks stay unchanged so the sequenced operands stay stable.
  - A dropped load pulses ld_err_o for one cycle, in the cycle after the edge.
  - ld_a_we_i and ld_b_we_i may both be high: both banks are written with the same address and data.
  - A load and start_i in the same IDLE edge: the load is written first, and the operation uses the new value.
- Counters:
  - The step counter is 3 bits and saturates logically at 6 via the state change. It never wraps while in FEED.
  - The drain counter is 4 bits.

Test Plan:
- Reset checks:
  - Assert rst_i for 2 cycles mid-FEED, then release -> IDLE.
  - All feeds=0, busy_o=0, done_o=0, arr_rst_no=0 during reset and 1 after.
  - Banks read back as 0: a start after reset feeds all zeros.
- Skew check:
  - Load A[r][c]=1+4r+c and B[r][c]=17+4r+c, then pulse start.
  - At FEED t=2: left_o_0..3 = 3, 6, 9, 0 and up_o_0..3 = 25, 22, 19, 0.
  - At t=6: left_o_3=16, up_o_3=32, all other feeds 0.
- Latency check: start edge -> CLEAR cycle with arr_rst_no=0 -> done_o high exactly 13 edges later for one cycle. busy_o is high for 12 cycles.
- Load rejection: during FEED t=3, write ld_a_we_i with addr=5, data=99 -> ld_err_o pulses once, and a later operation still feeds A[1][1]=6.
- Start handling:
  - start_i asserted during DRAIN and during DONE -> ignored, only one done_o.
  - start_i held high -> second CLEAR occurs 2 cycles after the first done_o.
- Simultaneous events: in IDLE, one edge with ld_a_we_i=1, ld_b_we_i=1, addr=0, data=7 and start_i=1 -> FEED t=0 gives left_o_0=7 and up_o_0=7.
